// File: rtl/move_controller_if.sv
// Bus between the movement FSM and its environment: frame/button inputs,
// collision checker flags and the candidate/committed positions.
interface move_controller_if;
    logic       frame_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [6:0] tamanho;
    logic       colisao_min_y;
    logic       colisao_max_y;
    logic       colisao_min_x;
    logic       colisao_max_x;
    logic [9:0] cand_x;
    logic [8:0] cand_y;
    logic [9:0] xPos;
    logic [8:0] yPos;
    logic       busy;
    logic       tick_missed;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right, tamanho,
               colisao_min_y, colisao_max_y, colisao_min_x, colisao_max_x,
        input  cand_x, cand_y, xPos, yPos, busy, tick_missed
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right, tamanho,
               colisao_min_y, colisao_max_y, colisao_min_x, colisao_max_x,
        output cand_x, cand_y, xPos, yPos, busy, tick_missed
    );
endinterface

// File: rtl/move_controller.sv
// Per-frame object mover: proposes a vertical then a horizontal step, waits for
// the external collision checkers to settle and commits each step if legal.
module move_controller #(
    parameter int STEP     = 1,
    parameter int WAIT_CYC = 2,
    parameter int X_INIT   = 20,
    parameter int Y_INIT   = 20
) (
    input  logic             VGA_clk,
    input  logic             rst_n,
    move_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, V_PROP, V_WAIT, V_DEC, H_PROP, H_WAIT, H_DEC
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_btn;
    logic [3:0]  r_cnt;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [10:0] r_cand_x;
    logic [10:0] r_cand_y;
    logic        r_tick_missed;

    logic        w_latch, w_load_v, w_load_h, w_cnt_clr, w_cnt_inc;
    logic        w_commit_x, w_commit_y;
    logic        w_v_up, w_v_dn, w_h_left, w_h_right, w_v_none, w_h_none;
    logic        w_y_ok, w_x_ok, w_y_flag, w_x_flag;
    logic [10:0] w_cy, w_cx;

    // r_btn = {up, down, left, right}; opposing requests cancel out
    assign w_v_up    = r_btn[3] & ~r_btn[2];
    assign w_v_dn    = r_btn[2] & ~r_btn[3];
    assign w_h_left  = r_btn[1] & ~r_btn[0];
    assign w_h_right = r_btn[0] & ~r_btn[1];
    assign w_v_none  = ~(w_v_up | w_v_dn);
    assign w_h_none  = ~(w_h_left | w_h_right);

    assign w_cy = w_v_up   ? ({2'b00, r_y} - 11'(STEP)) : ({2'b00, r_y} + 11'(STEP));
    assign w_cx = w_h_left ? ({1'b0, r_x} - 11'(STEP))  : ({1'b0, r_x} + 11'(STEP));

    // Bit 10 set means the 11-bit candidate went negative
    assign w_y_ok   = ~r_cand_y[10] && ((r_cand_y + {4'b0, bus.tamanho}) <= 11'd480);
    assign w_x_ok   = ~r_cand_x[10] && ((r_cand_x + {4'b0, bus.tamanho}) <= 11'd640);
    assign w_y_flag = w_v_up   ? bus.colisao_min_y : bus.colisao_max_y;
    assign w_x_flag = w_h_left ? bus.colisao_min_x : bus.colisao_max_x;

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_load_v   = 1'b0;
        w_load_h   = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_commit_x = 1'b0;
        w_commit_y = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.frame_tick) begin
                    w_latch = 1'b1;
                    w_next  = V_PROP;
                end
            end
            V_PROP: begin
                // No vertical move: do the H_PROP work in this same cycle
                if (w_v_none) begin
                    if (w_h_none) begin
                        w_next = IDLE;
                    end else begin
                        w_load_h  = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_next    = H_WAIT;
                    end
                end else begin
                    w_load_v  = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = V_WAIT;
                end
            end
            V_WAIT: begin
                if (r_cnt == LAST_WAIT) w_next = V_DEC;
                else                    w_cnt_inc = 1'b1;
            end
            V_DEC: begin
                w_commit_y = ~w_y_flag & w_y_ok;
                w_next     = H_PROP;
            end
            H_PROP: begin
                if (w_h_none) begin
                    w_next = IDLE;
                end else begin
                    w_load_h  = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = H_WAIT;
                end
            end
            H_WAIT: begin
                if (r_cnt == LAST_WAIT) w_next = H_DEC;
                else                    w_cnt_inc = 1'b1;
            end
            H_DEC: begin
                w_commit_x = ~w_x_flag & w_x_ok;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_btn         <= '0;
            r_cnt         <= '0;
            r_x           <= 10'(X_INIT);
            r_y           <= 9'(Y_INIT);
            r_cand_x      <= 11'(X_INIT);
            r_cand_y      <= 11'(Y_INIT);
            r_tick_missed <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_tick_missed <= bus.frame_tick && (r_state != IDLE);
            if (w_latch)
                r_btn <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
            if (w_load_v) begin
                r_cand_y <= w_cy;
                r_cand_x <= {1'b0, r_x};
            end
            if (w_load_h) begin
                r_cand_x <= w_cx;
                r_cand_y <= {2'b00, r_y};
            end
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 4'd1;
            if (w_commit_y) r_y <= r_cand_y[8:0];
            if (w_commit_x) r_x <= r_cand_x[9:0];
        end
    end

    assign bus.cand_x      = (r_state == IDLE) ? r_x : r_cand_x[9:0];
    assign bus.cand_y      = (r_state == IDLE) ? r_y : r_cand_y[8:0];
    assign bus.xPos        = r_x;
    assign bus.yPos        = r_y;
    assign bus.busy        = (r_state != IDLE);
    assign bus.tick_missed = r_tick_missed;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: one default instance plus one placed
// at the screen edge for the boundary cases.
module tb_move_controller;
    logic VGA_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    move_controller_if bus1();
    move_controller_if bus2();

    move_controller dut1 (.VGA_clk(VGA_clk), .rst_n(rst_n), .bus(bus1.slave));
    move_controller #(.STEP(1), .WAIT_CYC(2), .X_INIT(629), .Y_INIT(0))
        dut2 (.VGA_clk(VGA_clk), .rst_n(rst_n), .bus(bus2.slave));

    always #5 VGA_clk = ~VGA_clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge VGA_clk);
            #1;
        end
    endtask

    task automatic test_reset;
        cyc(2);
        checks++; if (bus1.xPos !== 10'd20) begin failures++; $display("[TB] FAIL reset_x got %0d want 20", bus1.xPos); end
        checks++; if (bus1.yPos !== 9'd20) begin failures++; $display("[TB] FAIL reset_y got %0d want 20", bus1.yPos); end
        checks++; if (bus1.cand_x !== 10'd20) begin failures++; $display("[TB] FAIL reset_cand_x got %0d want 20", bus1.cand_x); end
        checks++; if (bus1.cand_y !== 9'd20) begin failures++; $display("[TB] FAIL reset_cand_y got %0d want 20", bus1.cand_y); end
        checks++; if (bus1.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", bus1.busy); end
        checks++; if (bus1.tick_missed !== 1'b0) begin failures++; $display("[TB] FAIL reset_missed got %b want 0", bus1.tick_missed); end
        checks++; if (bus2.xPos !== 10'd629 || bus2.yPos !== 9'd0) begin failures++; $display("[TB] FAIL reset_dut2 got %0d,%0d want 629,0", bus2.xPos, bus2.yPos); end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_right_move;
        bus1.btn_right = 1'b1; bus1.frame_tick = 1'b1;
        cyc(1);
        bus1.btn_right = 1'b0; bus1.frame_tick = 1'b0;
        checks++; if (bus1.busy !== 1'b1) begin failures++; $display("[TB] FAIL right_busy got %b want 1", bus1.busy); end
        cyc(1);
        checks++; if (bus1.cand_x !== 10'd21) begin failures++; $display("[TB] FAIL right_cand_x got %0d want 21", bus1.cand_x); end
        cyc(7);
        checks++; if (bus1.xPos !== 10'd21) begin failures++; $display("[TB] FAIL right_x got %0d want 21", bus1.xPos); end
        checks++; if (bus1.yPos !== 9'd20) begin failures++; $display("[TB] FAIL right_y got %0d want 20", bus1.yPos); end
        checks++; if (bus1.busy !== 1'b0) begin failures++; $display("[TB] FAIL right_idle got %b want 0", bus1.busy); end
    endtask

    task automatic test_up_collision;
        bus1.btn_up = 1'b1; bus1.colisao_min_y = 1'b1; bus1.frame_tick = 1'b1;
        cyc(1);
        bus1.btn_up = 1'b0; bus1.frame_tick = 1'b0;
        cyc(1);
        checks++; if (bus1.cand_y !== 9'd19) begin failures++; $display("[TB] FAIL upcol_cand_y got %0d want 19", bus1.cand_y); end
        checks++; if (bus1.cand_x !== 10'd21) begin failures++; $display("[TB] FAIL upcol_cand_x got %0d want 21", bus1.cand_x); end
        cyc(7);
        checks++; if (bus1.yPos !== 9'd20) begin failures++; $display("[TB] FAIL upcol_y got %0d want 20", bus1.yPos); end
        checks++; if (bus1.busy !== 1'b0) begin failures++; $display("[TB] FAIL upcol_idle got %b want 0", bus1.busy); end
        bus1.colisao_min_y = 1'b0;
    endtask

    task automatic test_both_axes_latency;
        bus1.btn_down = 1'b1; bus1.btn_left = 1'b1; bus1.frame_tick = 1'b1;
        cyc(1);
        bus1.btn_down = 1'b0; bus1.btn_left = 1'b0; bus1.frame_tick = 1'b0;
        cyc(4);
        checks++; if (bus1.yPos !== 9'd21) begin failures++; $display("[TB] FAIL both_y got %0d want 21", bus1.yPos); end
        cyc(3);
        checks++; if (bus1.xPos !== 10'd21 || bus1.busy !== 1'b1) begin failures++; $display("[TB] FAIL both_early got x=%0d busy=%b want x=21 busy=1", bus1.xPos, bus1.busy); end
        cyc(1);
        checks++; if (bus1.xPos !== 10'd20 || bus1.busy !== 1'b0) begin failures++; $display("[TB] FAIL both_final got x=%0d busy=%b want x=20 busy=0", bus1.xPos, bus1.busy); end
    endtask

    task automatic test_conflict;
        int busyCount;
        busyCount = 0;
        bus1.btn_up = 1'b1; bus1.btn_down = 1'b1; bus1.btn_left = 1'b1; bus1.frame_tick = 1'b1;
        cyc(1);
        bus1.btn_up = 1'b0; bus1.btn_down = 1'b0; bus1.btn_left = 1'b0; bus1.frame_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus1.busy === 1'b1) busyCount++;
            cyc(1);
        end
        checks++; if (busyCount != 4) begin failures++; $display("[TB] FAIL conflict_busy_cycles got %0d want 4", busyCount); end
        checks++; if (bus1.yPos !== 9'd21) begin failures++; $display("[TB] FAIL conflict_y got %0d want 21", bus1.yPos); end
        checks++; if (bus1.xPos !== 10'd19) begin failures++; $display("[TB] FAIL conflict_x got %0d want 19", bus1.xPos); end
    endtask

    task automatic test_back_to_back;
        bus1.btn_right = 1'b1; bus1.frame_tick = 1'b1;
        cyc(1);
        bus1.btn_right = 1'b0; bus1.btn_left = 1'b1; bus1.frame_tick = 1'b0;
        checks++; if (bus1.tick_missed !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first got %b want 0", bus1.tick_missed); end
        cyc(2);
        bus1.frame_tick = 1'b1;
        cyc(1);
        bus1.frame_tick = 1'b0;
        checks++; if (bus1.tick_missed !== 1'b1) begin failures++; $display("[TB] FAIL b2b_missed got %b want 1", bus1.tick_missed); end
        cyc(1);
        checks++; if (bus1.tick_missed !== 1'b0) begin failures++; $display("[TB] FAIL b2b_pulse_len got %b want 0", bus1.tick_missed); end
        checks++; if (bus1.xPos !== 10'd20) begin failures++; $display("[TB] FAIL b2b_x got %0d want 20", bus1.xPos); end
        cyc(4);
        checks++; if (bus1.xPos !== 10'd20 || bus1.busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_single got x=%0d busy=%b want x=20 busy=0", bus1.xPos, bus1.busy); end
        bus1.btn_left = 1'b0;
    endtask

    task automatic test_reset_mid;
        bus1.btn_down = 1'b1; bus1.frame_tick = 1'b1;
        cyc(1);
        bus1.frame_tick = 1'b0;
        cyc(1);
        checks++; if (bus1.cand_y !== 9'd22) begin failures++; $display("[TB] FAIL rmid_cand_y got %0d want 22", bus1.cand_y); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus1.yPos !== 9'd20 || bus1.cand_y !== 9'd20) begin failures++; $display("[TB] FAIL rmid_async got y=%0d cand=%0d want 20,20", bus1.yPos, bus1.cand_y); end
        checks++; if (bus1.busy !== 1'b0 || bus1.xPos !== 10'd20) begin failures++; $display("[TB] FAIL rmid_state got busy=%b x=%0d want 0,20", bus1.busy, bus1.xPos); end
        cyc(1);
        rst_n = 1'b1;
        cyc(6);
        bus1.btn_down = 1'b0;
        checks++; if (bus1.yPos !== 9'd20 || bus1.busy !== 1'b0) begin failures++; $display("[TB] FAIL rmid_release got y=%0d busy=%b want 20,0", bus1.yPos, bus1.busy); end
    endtask

    task automatic test_bounds;
        bus2.btn_right = 1'b1; bus2.btn_up = 1'b1; bus2.frame_tick = 1'b1;
        cyc(1);
        bus2.btn_up = 1'b0; bus2.frame_tick = 1'b0;
        cyc(9);
        checks++; if (bus2.yPos !== 9'd0) begin failures++; $display("[TB] FAIL bound_top got %0d want 0", bus2.yPos); end
        checks++; if (bus2.xPos !== 10'd630) begin failures++; $display("[TB] FAIL bound_x_edge got %0d want 630", bus2.xPos); end
        bus2.frame_tick = 1'b1;
        cyc(1);
        bus2.btn_right = 1'b0; bus2.frame_tick = 1'b0;
        cyc(9);
        checks++; if (bus2.xPos !== 10'd630 || bus2.busy !== 1'b0) begin failures++; $display("[TB] FAIL bound_right got x=%0d busy=%b want 630,0", bus2.xPos, bus2.busy); end
        bus2.btn_left = 1'b1; bus2.frame_tick = 1'b1;
        cyc(1);
        bus2.btn_left = 1'b0; bus2.frame_tick = 1'b0;
        cyc(9);
        checks++; if (bus2.xPos !== 10'd629) begin failures++; $display("[TB] FAIL bound_left got %0d want 629", bus2.xPos); end
    endtask

    initial begin
        bus1.frame_tick = 1'b0; bus1.btn_up = 1'b0; bus1.btn_down = 1'b0;
        bus1.btn_left = 1'b0; bus1.btn_right = 1'b0; bus1.tamanho = 7'd10;
        bus1.colisao_min_y = 1'b0; bus1.colisao_max_y = 1'b0;
        bus1.colisao_min_x = 1'b0; bus1.colisao_max_x = 1'b0;
        bus2.frame_tick = 1'b0; bus2.btn_up = 1'b0; bus2.btn_down = 1'b0;
        bus2.btn_left = 1'b0; bus2.btn_right = 1'b0; bus2.tamanho = 7'd10;
        bus2.colisao_min_y = 1'b0; bus2.colisao_max_y = 1'b0;
        bus2.colisao_min_x = 1'b0; bus2.colisao_max_x = 1'b0;
        test_reset;
        test_right_move;
        test_up_collision;
        test_both_axes_latency;
        test_conflict;
        test_back_to_back;
        test_reset_mid;
        test_bounds;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter STEP, default 1, pixels moved per accepted step.
REQ-002 Parameter WAIT_CYC, default 2, VGA_clk cycles between driving a candidate position and sampling collision flags (range 1..15).
REQ-003 Parameter X_INIT, default 20, reset x position.
REQ-004 Parameter Y_INIT, default 20, reset y position.
REQ-005 VGA_clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse, one per video frame.
REQ-008 btn_up, btn_down, btn_left, btn_right  in  1 each  level direction requests.
REQ-009 tamanho  in  7  object side length in pixels.
REQ-010 colisao_min_y, colisao_max_y, colisao_min_x, colisao_max_x  in  1 each  collision flags from the per-direction checkers, evaluated on cand_x/cand_y.
REQ-011 cand_x  out  10  candidate x driven to checkers.
REQ-012 cand_y  out  9  candidate y driven to checkers.
REQ-013 xPos  out  10  committed object x.
REQ-014 yPos  out  9  committed object y.
REQ-015 busy  out  1  high while a frame's move sequence is in progress.
REQ-016 tick_missed  out  1  one-cycle pulse when frame_tick arrives while busy.

Function
REQ-017 FSM states SHALL be IDLE, V_PROP, V_WAIT, V_DEC, H_PROP, H_WAIT, H_DEC.
REQ-018 IDLE: cand_x/cand_y SHALL equal xPos/yPos; on frame_tick SHALL latch the four buttons and go to V_PROP.
REQ-019 Vertical direction SHALL be up if only latched up set, down if only down set, none otherwise (both or neither).
REQ-020 Horizontal direction SHALL be left if only left set, right if only right set, none otherwise.
REQ-021 V_PROP: if vertical none, go directly to H_PROP; else drive cand_y = yPos-STEP (up) or yPos+STEP (down), cand_x = xPos, clear wait counter, go to V_WAIT.
REQ-022 V_WAIT: hold candidates; count WAIT_CYC cycles, then go to V_DEC.
REQ-023 V_DEC: commit yPos <= cand_y only if the direction's flag (up: colisao_min_y, down: colisao_max_y) is 0 and bounds (REQ-027) pass; go to H_PROP.
REQ-024 H_PROP/H_WAIT/H_DEC SHALL mirror REQ-021..023 on x, using committed (possibly just-updated) yPos for cand_y, flags colisao_min_x (left) / colisao_max_x (right); H_DEC returns to IDLE.
REQ-025 Horizontal none in H_PROP SHALL return to IDLE in that cycle.
REQ-026 Candidate arithmetic SHALL be 11-bit signed-safe; no wrap-around is ever committed.
REQ-027 Bounds: commit requires 0 <= cand_y and cand_y + tamanho <= 480; 0 <= cand_x and cand_x + tamanho <= 640; else position unchanged.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 frame_tick in any non-IDLE state SHALL be ignored and SHALL pulse tick_missed the following cycle; buttons not relatched.
REQ-030 Button changes after latching SHALL not affect the current sequence.
REQ-031 Latency: no-collision, both axes moving, xPos/yPos final SHALL be visible 2*(WAIT_CYC+2) cycles after frame_tick sampled.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, xPos=X_INIT, yPos=Y_INIT, cand_x=X_INIT, cand_y=Y_INIT, busy=0, tick_missed=0, latched buttons=0, wait counter=0.
REQ-033 Reset asserted mid-sequence SHALL discard any pending candidate; no commit occurs on the release edge.

Verification
REQ-034 Reset, btn_right=1, tick, all flags 0 -> after 8 cycles xPos=21, yPos=20, busy 0.
REQ-035 btn_up=1, colisao_min_y=1 during V_DEC, tick -> yPos stays 20, cand_y showed 19 during V_WAIT.
REQ-036 btn_up+btn_down+btn_left, tick -> yPos unchanged, xPos 20->19, busy high 4 cycles only.
REQ-037 xPos=630, tamanho=10, btn_right, tick -> xPos stays 630; yPos=0, btn_up -> yPos stays 0.
REQ-038 Second frame_tick 3 cycles after first -> tick_missed pulse 1 cycle, single move only.
REQ-039 rst_n low during V_WAIT with btn_down -> yPos=Y_INIT, state IDLE, no commit after release.
